// File: rtl/uart_tx_arb.sv
// Four-requester round-robin arbiter feeding one UART transmitter.
// A requester that sends a byte without req_last keeps the transmitter until its packet ends.
//
//   state | meaning
//   IDLE  | no byte in flight; arbitrate, or hold or release a locked owner
//   SEND  | one-cycle tx_start/ack strobe for the owner's byte
//   WAIT  | byte on the line; wait for tx_done or abort on timeout
module uart_tx_arb #(
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   input  logic [3:0]  req_last,
   output logic [3:0]  ack,
   output logic [3:0]  gnt,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic        busy,
   output logic        err,
   output logic [15:0] byte_cnt
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   localparam logic [15:0] TERM_CNT = 16'(TIMEOUT - 1);

   state_t      state_q;
   logic [1:0]  ptr_q;
   logic [1:0]  owner_q;
   logic        lock_q;
   logic        last_q;
   logic [15:0] wait_q;
   logic [15:0] byte_cnt_q;
   logic [3:0]  ack_q;
   logic [3:0]  gnt_q;
   logic        tx_start_q;
   logic [7:0]  tx_data_q;
   logic        busy_q;
   logic        err_q;

   logic        pick_valid;
   logic [1:0]  pick_idx;
   logic [1:0]  cand;
   logic        go_d;
   logic [1:0]  owner_d;

   // Scan from the highest offset down so the lowest offset from ptr wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = ptr_q;
      cand       = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr_q + 2'(k);
         if (req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      owner_d = lock_q ? owner_q : pick_idx;
      go_d    = lock_q ? req[owner_q] : pick_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= 2'd0;
         owner_q    <= 2'd0;
         lock_q     <= 1'b0;
         last_q     <= 1'b0;
         wait_q     <= 16'd0;
         byte_cnt_q <= 16'd0;
         ack_q      <= 4'd0;
         gnt_q      <= 4'd0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'd0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         ack_q      <= 4'd0;
         tx_start_q <= 1'b0;
         err_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               // Outputs are registered, so the byte and its strobes are captured
               // on the way into SEND and are visible during the SEND cycle.
               if (go_d) begin
                  owner_q    <= owner_d;
                  last_q     <= req_last[owner_d];
                  tx_data_q  <= req_data[{owner_d, 3'b000} +: 8];
                  ack_q      <= 4'b0001 << owner_d;
                  gnt_q      <= 4'b0001 << owner_d;
                  tx_start_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= SEND;
               end else if (lock_q) begin
                  lock_q <= 1'b0;
                  ptr_q  <= owner_q + 2'd1;
               end
            end
            SEND: begin
               wait_q  <= 16'd0;
               state_q <= WAIT;
            end
            WAIT: begin
               wait_q <= wait_q + 16'd1;
               if (tx_done) begin
                  byte_cnt_q <= byte_cnt_q + 16'd1;
                  lock_q     <= ~last_q;
                  if (last_q) ptr_q <= owner_q + 2'd1;
                  gnt_q      <= 4'd0;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end else if (wait_q == TERM_CNT) begin
                  err_q   <= 1'b1;
                  lock_q  <= 1'b0;
                  ptr_q   <= owner_q + 2'd1;
                  gnt_q   <= 4'd0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack      = ack_q;
   assign gnt      = gnt_q;
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_q;
   assign err      = err_q;
   assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: default-TIMEOUT instance plus a TIMEOUT=16 instance on shared inputs.
module tb_uart_tx_arb;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic        tx_done;

   logic [3:0]  ack, gnt;
   logic        tx_start, busy, err;
   logic [7:0]  tx_data;
   logic [15:0] byte_cnt;

   logic [3:0]  ack16, gnt16;
   logic        tx_start16, busy16, err16;
   logic [7:0]  tx_data16;
   logic [15:0] byte_cnt16;

   int checks = 0;
   int errors = 0;

   uart_tx_arb u_dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
      .ack(ack), .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
      .busy(busy), .err(err), .byte_cnt(byte_cnt)
   );

   uart_tx_arb #(.TIMEOUT(16)) u_dut16 (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
      .ack(ack16), .gnt(gnt16), .tx_start(tx_start16), .tx_data(tx_data16), .tx_done(tx_done),
      .busy(busy16), .err(err16), .byte_cnt(byte_cnt16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst      = 1'b1;
      req      = 4'd0;
      req_data = 32'd0;
      req_last = 4'd0;
      tx_done  = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (tx_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_done;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
   endtask

   task automatic test_reset;
      apply_reset();
      checks++; if ({ack, gnt, tx_start, tx_data, busy, err} !== 19'd0) begin errors++;
         $display("FAIL reset_outputs: got %h want 0", {ack, gnt, tx_start, tx_data, busy, err}); end
      checks++; if (byte_cnt !== 16'd0) begin errors++;
         $display("FAIL reset_byte_cnt: got %0d want 0", byte_cnt); end
      checks++; if ({ack16, gnt16, tx_start16, busy16, err16, byte_cnt16} !== 27'd0) begin errors++;
         $display("FAIL reset_outputs16: got %h want 0", {ack16, gnt16, tx_start16, busy16, err16, byte_cnt16}); end
   endtask

   task automatic test_single;
      apply_reset();
      req = 4'b0001; req_data = 32'hDEAD_BE55; req_last = 4'b0001;
      step();
      checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_tx_start: got %b want 1", tx_start); end
      checks++; if (tx_data !== 8'h55) begin errors++; $display("FAIL single_tx_data: got %h want 55", tx_data); end
      checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b want 0001", ack); end
      checks++; if (gnt !== 4'b0001 || busy !== 1'b1) begin errors++;
         $display("FAIL single_gnt_busy: got %b/%b want 0001/1", gnt, busy); end
      req = 4'b0000;
      step();
      checks++; if (tx_start !== 1'b0 || ack !== 4'd0 || tx_data !== 8'h55) begin errors++;
         $display("FAIL single_strobe_end: got %b/%b/%h want 0/0000/55", tx_start, ack, tx_data); end
      repeat (2009) step();
      pulse_done();
      checks++; if (byte_cnt !== 16'd1) begin errors++; $display("FAIL single_byte_cnt: got %0d want 1", byte_cnt); end
      checks++; if (busy !== 1'b0 || gnt !== 4'd0 || err !== 1'b0) begin errors++;
         $display("FAIL single_idle: got busy %b gnt %b err %b want 0/0000/0", busy, gnt, err); end
      // ptr must now be 1: requester 1 wins over requester 0
      req = 4'b0011;
      step();
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL single_ptr: got gnt %b want 0010", gnt); end
      req = 4'b0000;
   endtask

   task automatic test_round_robin;
      bit ok;
      int ack_total;
      int exp;
      apply_reset();
      req = 4'b1111; req_data = 32'hA3A2_A1A0; req_last = 4'b1111;
      ack_total = 0;
      for (int i = 0; i < 5; i++) begin
         exp = i % 4;
         wait_start(ok);
         checks++; if (!ok) begin errors++; $display("FAIL rr_start_timeout: byte %0d got no tx_start want tx_start", i); end
         checks++; if (gnt !== 4'(1 << exp)) begin errors++;
            $display("FAIL rr_gnt: byte %0d got %b want %b", i, gnt, 4'(1 << exp)); end
         checks++; if (tx_data !== 8'hA0 + 8'(exp)) begin errors++;
            $display("FAIL rr_data: byte %0d got %h want %h", i, tx_data, 8'hA0 + 8'(exp)); end
         ack_total += $countones(ack);
         repeat (3) begin
            step();
            ack_total += $countones(ack);
         end
         pulse_done();
         ack_total += $countones(ack);
      end
      checks++; if (ack_total != 5) begin errors++; $display("FAIL rr_ack_count: got %0d want 5", ack_total); end
      checks++; if (byte_cnt !== 16'd5) begin errors++; $display("FAIL rr_byte_cnt: got %0d want 5", byte_cnt); end
      req = 4'b0000;
   endtask

   task automatic test_packet_lock;
      bit ok;
      apply_reset();
      req = 4'b0101; req_data = 32'h0020_0010; req_last = 4'b0100;
      for (int b = 0; b < 3; b++) begin
         wait_start(ok);
         checks++; if (!ok || gnt !== 4'b0001) begin errors++;
            $display("FAIL lock_gnt: byte %0d got %b want 0001", b, gnt); end
         checks++; if (tx_data !== 8'h10 + 8'(b)) begin errors++;
            $display("FAIL lock_data: byte %0d got %h want %h", b, tx_data, 8'h10 + 8'(b)); end
         req_data[7:0] = 8'h11 + 8'(b);
         req_last[0]   = (b == 1);
         if (b == 2) req[0] = 1'b0;
         repeat (2) step();
         pulse_done();
      end
      wait_start(ok);
      checks++; if (!ok || gnt !== 4'b0100 || tx_data !== 8'h20) begin errors++;
         $display("FAIL lock_handover: got gnt %b data %h want 0100 20", gnt, tx_data); end
      req = 4'b0000;
   endtask

   task automatic test_lock_release;
      bit ok;
      apply_reset();
      req = 4'b0101; req_data = 32'h0033_0044; req_last = 4'b0000;
      wait_start(ok);
      checks++; if (!ok || gnt !== 4'b0001) begin errors++; $display("FAIL release_first: got %b want 0001", gnt); end
      req = 4'b0100;
      repeat (2) step();
      pulse_done();
      step();
      checks++; if (tx_start !== 1'b0 || gnt !== 4'd0 || err !== 1'b0) begin errors++;
         $display("FAIL release_idle: got start %b gnt %b err %b want 0/0000/0", tx_start, gnt, err); end
      step();
      checks++; if (tx_start !== 1'b1 || gnt !== 4'b0100) begin errors++;
         $display("FAIL release_next: got start %b gnt %b want 1/0100", tx_start, gnt); end
      req = 4'b0000;
   endtask

   task automatic test_timeout;
      apply_reset();
      req = 4'b0001; req_data = 32'h0000_00C3; req_last = 4'b0001;
      step();
      checks++; if (tx_start16 !== 1'b1) begin errors++; $display("FAIL to_start: got %b want 1", tx_start16); end
      req = 4'b0000;
      repeat (16) step();
      checks++; if (err16 !== 1'b0 || busy16 !== 1'b1) begin errors++;
         $display("FAIL to_early: got err %b busy %b want 0/1", err16, busy16); end
      step();
      checks++; if (err16 !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err16); end
      checks++; if (byte_cnt16 !== 16'd0 || gnt16 !== 4'd0) begin errors++;
         $display("FAIL to_state: got cnt %0d gnt %b want 0/0000", byte_cnt16, gnt16); end
      step();
      checks++; if (err16 !== 1'b0 || busy16 !== 1'b0) begin errors++;
         $display("FAIL to_after: got err %b busy %b want 0/0", err16, busy16); end
   endtask

   task automatic test_done_vs_timeout;
      apply_reset();
      req = 4'b0001; req_data = 32'h0000_003C; req_last = 4'b0001;
      step();
      checks++; if (tx_start16 !== 1'b1) begin errors++; $display("FAIL tie_start: got %b want 1", tx_start16); end
      req = 4'b0000;
      repeat (16) step();
      pulse_done();
      checks++; if (err16 !== 1'b0 || byte_cnt16 !== 16'd1 || busy16 !== 1'b0) begin errors++;
         $display("FAIL tie_result: got err %b cnt %0d busy %b want 0/1/0", err16, byte_cnt16, busy16); end
      step();
      checks++; if (err16 !== 1'b0) begin errors++; $display("FAIL tie_late_err: got %b want 0", err16); end
   endtask

   task automatic test_reset_mid_wait;
      bit ok;
      apply_reset();
      req = 4'b0001; req_data = 32'h0000_0077; req_last = 4'b0001;
      wait_start(ok);
      repeat (2) step();
      pulse_done();
      wait_start(ok);
      req = 4'b0000;
      repeat (4) step();
      checks++; if (busy !== 1'b1 || byte_cnt !== 16'd1) begin errors++;
         $display("FAIL rmw_pre: got busy %b cnt %0d want 1/1", busy, byte_cnt); end
      rst = 1'b1; req = 4'b1000;
      step();
      checks++; if ({ack, gnt, tx_start, tx_data, busy, err} !== 19'd0 || byte_cnt !== 16'd0) begin errors++;
         $display("FAIL rmw_in_reset: got %h cnt %0d want 0/0", {ack, gnt, tx_start, tx_data, busy, err}, byte_cnt); end
      step();
      rst = 1'b0;
      step();
      checks++; if (gnt !== 4'b1000 || tx_start !== 1'b1 || err !== 1'b0) begin errors++;
         $display("FAIL rmw_resume: got gnt %b start %b err %b want 1000/1/0", gnt, tx_start, err); end
      req = 4'b0000;
   endtask

   initial begin
      rst = 1'b1; req = 4'd0; req_data = 32'd0; req_last = 4'd0; tx_done = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_packet_lock();
      test_lock_release();
      test_timeout();
      test_done_vs_timeout();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
